// File: rtl/sprite_engine.sv
// Multi-sprite overlay on the VGA x/y pixel path with two-stage hit/priority pipeline.
// Optional sticky overlap detection is built when SPRITE_COLLISION_EN is defined.
module sprite_engine #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPRITE_W    = 4,
  parameter int unsigned SPRITE_H    = 4,
  parameter int unsigned XW          = 8,
  parameter int unsigned YW          = 7,
  parameter logic [2:0]  BG_COLOR    = 3'b000,
  localparam int unsigned IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int unsigned RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
  input  logic                VGA_CLK,
  input  logic                RESETN,
  input  logic                frame_start,
  input  logic [XW-1:0]       xvga,
  input  logic [YW-1:0]       yvga,
  input  logic                pix_valid,
  input  logic                wr_en,
  input  logic [1:0]          wr_sel,
  input  logic [IW-1:0]       wr_idx,
  input  logic [RW-1:0]       wr_row,
  input  logic [XW-1:0]       wr_x,
  input  logic [YW-1:0]       wr_y,
  input  logic [2:0]          wr_color,
  input  logic                wr_enable,
  input  logic [SPRITE_W-1:0] wr_mask,
  output logic [2:0]          pixel,
  output logic                pixel_hit,
  output logic                pixel_valid,
  output logic [IW-1:0]       pixel_id,
  output logic                collision
);

  localparam int unsigned CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;

  logic [XW-1:0]       sh_x_q     [NUM_SPRITES];
  logic [YW-1:0]       sh_y_q     [NUM_SPRITES];
  logic [2:0]          sh_color_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] sh_en_q;
  logic [SPRITE_W-1:0] sh_mask_q  [NUM_SPRITES][SPRITE_H];

  logic [XW-1:0]       lv_x_q     [NUM_SPRITES];
  logic [YW-1:0]       lv_y_q     [NUM_SPRITES];
  logic [2:0]          lv_color_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] lv_en_q;
  logic [SPRITE_W-1:0] lv_mask_q  [NUM_SPRITES][SPRITE_H];

  logic [NUM_SPRITES-1:0] hit_d, hit_q;
  logic [2:0]          color1_q [NUM_SPRITES];
  logic                valid1_q;

  logic [2:0]          pixel_q;
  logic                pixel_hit_q, pixel_valid_q;
  logic [IW-1:0]       pixel_id_q;

  // Out-of-range index/row never matches a loop constant, so it writes nothing.
  always_ff @(posedge VGA_CLK or negedge RESETN) begin
    if (!RESETN) begin
      sh_en_q <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sh_x_q[i]     <= '0;
        sh_y_q[i]     <= '0;
        sh_color_q[i] <= '0;
        for (int r = 0; r < SPRITE_H; r++) sh_mask_q[i][r] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (wr_idx == IW'(i)) begin
          case (wr_sel)
            2'd0: begin
              sh_x_q[i] <= wr_x;
              sh_y_q[i] <= wr_y;
            end
            2'd1: begin
              sh_color_q[i] <= wr_color;
              sh_en_q[i]    <= wr_enable;
            end
            2'd2: begin
              for (int r = 0; r < SPRITE_H; r++) begin
                if (wr_row == RW'(r)) sh_mask_q[i][r] <= wr_mask;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge VGA_CLK or negedge RESETN) begin
    if (!RESETN) begin
      lv_en_q <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        lv_x_q[i]     <= '0;
        lv_y_q[i]     <= '0;
        lv_color_q[i] <= '0;
        for (int r = 0; r < SPRITE_H; r++) lv_mask_q[i][r] <= '0;
      end
    end else if (frame_start) begin
      lv_en_q <= sh_en_q;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        lv_x_q[i]     <= sh_x_q[i];
        lv_y_q[i]     <= sh_y_q[i];
        lv_color_q[i] <= sh_color_q[i];
        for (int r = 0; r < SPRITE_H; r++) lv_mask_q[i][r] <= sh_mask_q[i][r];
      end
    end
  end

  // The top bit of dx/dy is the borrow: scan position left of or above the sprite.
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    logic [XW:0] dx;
    logic [YW:0] dy;
    logic        in_box;
    assign dx     = {1'b0, xvga} - {1'b0, lv_x_q[g]};
    assign dy     = {1'b0, yvga} - {1'b0, lv_y_q[g]};
    assign in_box = lv_en_q[g] && !dx[XW] && (dx < (XW+1)'(SPRITE_W))
                    && !dy[YW] && (dy < (YW+1)'(SPRITE_H));
    assign hit_d[g] = in_box && lv_mask_q[g][dy[RW-1:0]][dx[CW-1:0]];
  end

  // Colours travel with the hits so a commit never recolours an in-flight pixel.
  always_ff @(posedge VGA_CLK or negedge RESETN) begin
    if (!RESETN) begin
      hit_q    <= '0;
      valid1_q <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) color1_q[i] <= '0;
    end else begin
      hit_q    <= hit_d;
      valid1_q <= pix_valid;
      for (int i = 0; i < NUM_SPRITES; i++) color1_q[i] <= lv_color_q[i];
    end
  end

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [2:0]    win_color;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_color = BG_COLOR;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
        win_color = color1_q[i];
      end
    end
  end

  always_ff @(posedge VGA_CLK or negedge RESETN) begin
    if (!RESETN) begin
      pixel_q       <= '0;
      pixel_hit_q   <= 1'b0;
      pixel_id_q    <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_valid_q <= valid1_q;
      if (valid1_q) begin
        pixel_q     <= win_color;
        pixel_hit_q <= win_found;
        pixel_id_q  <= win_idx;
      end else begin
        pixel_q     <= '0;
        pixel_hit_q <= 1'b0;
        pixel_id_q  <= '0;
      end
    end
  end

  assign pixel       = pixel_q;
  assign pixel_hit   = pixel_hit_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_id    = pixel_id_q;

`ifdef SPRITE_COLLISION_EN
  logic collision_q;
  logic multi_hit;

  // Clearing the lowest set bit leaves something only if two or more hits are set.
  assign multi_hit = |(hit_d & (hit_d - NUM_SPRITES'(1)));

  always_ff @(posedge VGA_CLK or negedge RESETN) begin
    if (!RESETN) begin
      collision_q <= 1'b0;
    end else if (frame_start) begin
      collision_q <= 1'b0;
    end else if (pix_valid && multi_hit) begin
      collision_q <= 1'b1;
    end
  end

  assign collision = collision_q;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_engine.sv
// Directed self-checking bench for sprite_engine using default parameters.
module tb_sprite_engine;

  logic       VGA_CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] xvga = '0;
  logic [6:0] yvga = '0;
  logic       pix_valid = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_sel = '0;
  logic [1:0] wr_idx = '0;
  logic [1:0] wr_row = '0;
  logic [7:0] wr_x = '0;
  logic [6:0] wr_y = '0;
  logic [2:0] wr_color = '0;
  logic       wr_enable = 1'b0;
  logic [3:0] wr_mask = '0;
  logic [2:0] pixel;
  logic       pixel_hit;
  logic       pixel_valid;
  logic [1:0] pixel_id;
  logic       collision;

  logic [6:0] obs;
  int n_cmp = 0;
  int n_fail = 0;

`ifdef SPRITE_COLLISION_EN
  localparam logic EXP_COLL = 1'b1;
`else
  localparam logic EXP_COLL = 1'b0;
`endif

  sprite_engine dut (
    .VGA_CLK    (VGA_CLK),
    .RESETN     (RESETN),
    .frame_start(frame_start),
    .xvga       (xvga),
    .yvga       (yvga),
    .pix_valid  (pix_valid),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_idx     (wr_idx),
    .wr_row     (wr_row),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_color   (wr_color),
    .wr_enable  (wr_enable),
    .wr_mask    (wr_mask),
    .pixel      (pixel),
    .pixel_hit  (pixel_hit),
    .pixel_valid(pixel_valid),
    .pixel_id   (pixel_id),
    .collision  (collision)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  // {valid, hit, id[1:0], pixel[2:0]}
  assign obs = {pixel_valid, pixel_hit, pixel_id, pixel};

  task automatic wr(input int sel, input int idx, input int row, input int x, input int y,
                    input int c, input int en, input int m);
    wr_sel = 2'(sel); wr_idx = 2'(idx); wr_row = 2'(row);
    wr_x = 8'(x); wr_y = 7'(y); wr_color = 3'(c); wr_enable = 1'(en); wr_mask = 4'(m);
    wr_en = 1'b1;
    @(posedge VGA_CLK); #1;
    wr_en = 1'b0;
  endtask

  task automatic set_rows(input int idx, input int m);
    for (int r = 0; r < 4; r++) wr(2, idx, r, 0, 0, 0, 0, m);
  endtask

  task automatic commit();
    pix_valid = 1'b0;
    frame_start = 1'b1;
    @(posedge VGA_CLK); #1;
    frame_start = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic v);
    xvga = 8'(x); yvga = 7'(y); pix_valid = v;
    @(posedge VGA_CLK); @(posedge VGA_CLK); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge VGA_CLK);
    #1;
    n_cmp++;
    if ({obs, collision} !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs: got %b want %b", {obs, collision}, 8'h00);
    end
    RESETN = 1'b1;
    @(posedge VGA_CLK); #1;
  endtask

  task automatic test_defaults();
    int         xs [7] = '{0, 4, 7, 8, 3, 4, 4};
    int         ys [7] = '{0, 16, 19, 20, 16, 15, 16};
    logic       vs [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic [6:0] ex [7] = '{7'b1000000, 7'b1100101, 7'b1100101, 7'b1000000,
                           7'b1000000, 7'b1000000, 7'b0000000};
    wr(0, 0, 0, 4, 16, 0, 0, 0);
    wr(1, 0, 0, 0, 0, 3'b101, 1, 0);
    set_rows(0, 4'hF);
    commit();
    for (int k = 0; k < 7; k++) begin
      pix(xs[k], ys[k], vs[k]);
      n_cmp++;
      if (obs !== ex[k]) begin
        n_fail++;
        $display("FAIL defaults[%0d] (%0d,%0d): got %b want %b", k, xs[k], ys[k], obs, ex[k]);
      end
    end
  endtask

  task automatic test_mask();
    int         xs [3] = '{5, 4, 6};
    logic [6:0] ex [3] = '{7'b1100101, 7'b1000000, 7'b1000000};
    wr(2, 0, 1, 0, 0, 0, 0, 4'b0010);
    commit();
    for (int k = 0; k < 3; k++) begin
      pix(xs[k], 17, 1'b1);
      n_cmp++;
      if (obs !== ex[k]) begin
        n_fail++; $display("FAIL mask[%0d] (%0d,17): got %b want %b", k, xs[k], obs, ex[k]);
      end
    end
    wr(2, 0, 1, 0, 0, 0, 0, 4'hF);
  endtask

  task automatic test_priority();
    wr(1, 0, 0, 0, 0, 3'b001, 1, 0);
    wr(0, 1, 0, 6, 16, 0, 0, 0);
    wr(1, 1, 0, 0, 0, 3'b110, 1, 0);
    set_rows(1, 4'hF);
    commit();
    n_cmp++;
    if (collision !== 1'b0) begin
      n_fail++; $display("FAIL coll_idle: got %b want 0", collision);
    end
    xvga = 8'd6; yvga = 7'd16; pix_valid = 1'b1;
    @(posedge VGA_CLK); #1;
    n_cmp++;
    if (collision !== EXP_COLL) begin
      n_fail++; $display("FAIL coll_set: got %b want %b", collision, EXP_COLL);
    end
    @(posedge VGA_CLK); #1;
    n_cmp++;
    if (obs !== 7'b1100001) begin
      n_fail++; $display("FAIL prio_both: got %b want %b", obs, 7'b1100001);
    end
    pix(8, 16, 1'b1);
    n_cmp++;
    if ({obs, collision} !== {7'b1101110, EXP_COLL}) begin
      n_fail++;
      $display("FAIL prio_s1_sticky: got %b want %b", {obs, collision}, {7'b1101110, EXP_COLL});
    end
    wr(1, 0, 0, 0, 0, 3'b001, 0, 0);
    commit();
    n_cmp++;
    if (collision !== 1'b0) begin
      n_fail++; $display("FAIL coll_clear: got %b want 0", collision);
    end
    pix(6, 16, 1'b1);
    n_cmp++;
    if ({obs, collision} !== {7'b1101110, 1'b0}) begin
      n_fail++; $display("FAIL prio_s0_off: got %b want %b", {obs, collision}, {7'b1101110, 1'b0});
    end
  endtask

  task automatic test_shadow();
    int         xa [4] = '{40, 43, 44, 4};
    logic [6:0] ea [4] = '{7'b1100101, 7'b1100101, 7'b1000000, 7'b1000000};
    int         xb [3] = '{80, 83, 40};
    logic [6:0] eb [3] = '{7'b1100101, 7'b1100101, 7'b1000000};
    wr(1, 1, 0, 0, 0, 0, 0, 0);
    wr(1, 0, 0, 0, 0, 3'b101, 1, 0);
    wr(0, 0, 0, 4, 16, 0, 0, 0);
    commit();
    wr(0, 0, 0, 40, 16, 0, 0, 0);
    pix(4, 16, 1'b1);
    n_cmp++;
    if (obs !== 7'b1100101) begin
      n_fail++; $display("FAIL shadow_hold: got %b want %b", obs, 7'b1100101);
    end
    // Commit and write in the same cycle: the new x must wait for the next commit.
    pix_valid = 1'b0;
    wr_sel = 2'd0; wr_idx = 2'd0; wr_x = 8'd80; wr_y = 7'd16; wr_en = 1'b1; frame_start = 1'b1;
    @(posedge VGA_CLK); #1;
    wr_en = 1'b0; frame_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pix(xa[k], 16, 1'b1);
      n_cmp++;
      if (obs !== ea[k]) begin
        n_fail++; $display("FAIL shadow_a[%0d] x=%0d: got %b want %b", k, xa[k], obs, ea[k]);
      end
    end
    wr(3, 0, 0, 0, 16, 3'b010, 0, 0);
    commit();
    for (int k = 0; k < 3; k++) begin
      pix(xb[k], 16, 1'b1);
      n_cmp++;
      if (obs !== eb[k]) begin
        n_fail++; $display("FAIL shadow_b[%0d] x=%0d: got %b want %b", k, xb[k], obs, eb[k]);
      end
    end
  endtask

  task automatic test_clip_reset();
    int         xs [4] = '{255, 254, 0, 253};
    logic [6:0] ex [4] = '{7'b1100101, 7'b1100101, 7'b1000000, 7'b1000000};
    wr(0, 0, 0, 254, 16, 0, 0, 0);
    commit();
    for (int k = 0; k < 4; k++) begin
      pix(xs[k], 16, 1'b1);
      n_cmp++;
      if (obs !== ex[k]) begin
        n_fail++; $display("FAIL clip[%0d] x=%0d: got %b want %b", k, xs[k], obs, ex[k]);
      end
    end
    wr(0, 0, 0, 4, 16, 0, 0, 0);
    commit();
    pix(4, 16, 1'b1);
    n_cmp++;
    if (obs !== 7'b1100101) begin
      n_fail++; $display("FAIL pre_reset: got %b want %b", obs, 7'b1100101);
    end
    RESETN = 1'b0;
    #1;
    n_cmp++;
    if ({obs, collision} !== 8'h00) begin
      n_fail++; $display("FAIL async_reset: got %b want %b", {obs, collision}, 8'h00);
    end
    @(posedge VGA_CLK); #1;
    RESETN = 1'b1;
    @(posedge VGA_CLK); #1;
    n_cmp++;
    if (obs !== 7'b0000000) begin
      n_fail++; $display("FAIL post_reset_1: got %b want %b", obs, 7'b0000000);
    end
    @(posedge VGA_CLK); #1;
    n_cmp++;
    if (obs !== 7'b1000000) begin
      n_fail++; $display("FAIL post_reset_2: got %b want %b", obs, 7'b1000000);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_defaults();
    test_mask();
    test_priority();
    test_shadow();
    test_clip_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_engine.md
Name: sprite_engine

Overview:
Parametrised multi-sprite overlay for the VGA_XY pixel path. It holds NUM_SPRITES sprites, each with a position, a colour, an enable and a SPRITE_W x SPRITE_H one-bit mask. The block compares the scan coordinate (xvga, yvga) against every sprite and returns the colour of the highest-priority opaque hit, two cycles later. Software-side writes go to shadow registers, which are committed to the live set on frame_start so that sprites never tear mid-frame.

Parameters:
NUM_SPRITES, 4, number of sprites (1..16); index 0 has the highest priority
SPRITE_W, 4, sprite width in pixels (1..16)
SPRITE_H, 4, sprite height in pixels (1..16)
XW, 8, width of x coordinates
YW, 7, width of y coordinates
BG_COLOR, 3'b000, pixel value driven when there is no sprite hit

Ports:
VGA_CLK  in  1  pixel clock; all state changes on the rising edge
RESETN  in  1  asynchronous, active-low reset
frame_start  in  1  one-cycle pulse at vertical blank; commits shadow to live, clears collision
xvga  in  XW  current scan x
yvga  in  YW  current scan y
pix_valid  in  1  qualifies xvga/yvga as an active-video pixel
wr_en  in  1  shadow write strobe
wr_sel  in  2  write target: 0 = position, 1 = colour+enable, 2 = mask row, 3 = ignored
wr_idx  in  IW=$clog2(NUM_SPRITES) (min 1)  sprite index
wr_row  in  RW=$clog2(SPRITE_H) (min 1)  mask row for wr_sel=2
wr_x  in  XW  new x (top-left corner)
wr_y  in  YW  new y (top-left corner)
wr_color  in  3  new colour
wr_enable  in  1  new visible flag
wr_mask  in  SPRITE_W  mask row; bit 0 is the leftmost column
pixel  out  3  output colour
pixel_hit  out  1  a sprite supplied this pixel
pixel_valid  out  1  pix_valid delayed by 2
pixel_id  out  IW  index of the winning sprite (0 when no hit)
collision  out  1  sticky overlap flag

Behaviour:
- Reset (async assert, sync release): all shadow and live registers are 0, so every sprite is disabled. All outputs are 0.
- Writes: when wr_en=1, the selected field of shadow[wr_idx] is updated at the clock edge. Any wr_idx >= NUM_SPRITES, any wr_row >= SPRITE_H, or wr_sel=3 produces no write.
- Commit: on the frame_start edge, live <= shadow as it stood before that edge. A write in the same cycle lands in shadow only and becomes visible at the next frame_start.
- Stage 1 (registered), per sprite i:
  - dx = {1'b0,xvga} - {1'b0,x_i}, dy likewise, computed at XW+1 / YW+1 bits.
  - The pixel is in the box iff enable_i, dx < SPRITE_W, dy < SPRITE_H, and there is no borrow.
  - There is no wrap-around: sprites near the coordinate maximum are clipped at the right and bottom edges.
  - hit_i = in_box & mask_i[dy][dx].
- Stage 2 (registered): the lowest i with hit_i wins.
  - pixel = color_i, pixel_hit = 1, pixel_id = i.
  - With no hit: pixel = BG_COLOR, pixel_hit = 0, pixel_id = 0.
  - If the stage-1 pix_valid was 0: pixel = 0, pixel_hit = 0, pixel_id = 0, independent of hits.
- Latency: exactly 2 cycles from xvga/yvga/pix_valid to all outputs. Full throughput, one pixel per clock, no stalls.
- The pipeline uses live registers only; a commit affects pixels sampled from the next cycle onwards.
- A reset asserted mid-frame clears the pipeline immediately; outputs are 0 until two valid pixels have been sampled after release.

Optional Feature:
SPRITE_COLLISION_EN
- Defined: collision is set when a stage-1 pixel with pix_valid has two or more hit_i asserted. It stays set until frame_start or reset. frame_start clears it and takes priority over a set in the same cycle.
- Undefined: collision is tied to 0 and no collision logic is synthesised.

Test Plan:
1. Defaults. Write sprite 0: pos (4,16), colour 3'b101, enable 1, all mask rows 4'hF; pulse frame_start. Sweep (0,0), (4,16), (7,19), (8,20) with pix_valid=1. Outputs 2 cycles later: pixel = 000, 101, 101, 000; pixel_hit = 0, 1, 1, 0.
2. Mask. Set sprite 0 row 1 mask = 4'b0010; commit; sample (5,17) -> hit; (4,17) -> pixel = BG_COLOR, pixel_hit = 0.
3. Priority. Sprite 0 colour 001 at (4,16); sprite 1 colour 110 at (6,16); sample (6,16) -> pixel 001, pixel_id 0. Disable sprite 0 and commit -> pixel 110, pixel_id 1.
4. Shadow. Rewrite sprite 0 x=40 without frame_start -> (4,16) still hits. Pulse frame_start with a simultaneous write of x=80 -> hits at x = 40..43; after the next frame_start -> hits at x = 80..83.
5. Clip and reset. Sprite at x=254, sample xvga=255 -> hit; xvga=0 -> no hit. Assert RESETN=0 mid-scan -> all outputs 0 at once; after release, (4,16) gives no hit.
6. Collision (with SPRITE_COLLISION_EN). Overlap sprites 0 and 1 at (6,16) -> collision=1 from 1 cycle after that sample; frame_start -> collision=0 next cycle. Macro undefined -> collision stays 0.
